// File: rtl/ntt_pkg.sv
// -----------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT1024 datapath and its output collector.
//   MAX_DEPTH         : log2 of the largest supported ring size
//   PE_DEPTH          : pipeline depth of one butterfly processing element
//   Q_DEFAULT         : modulus used by the collector until the first done
//   OP_*              : operation codes understood by the NTT core
//   collector_state_e : state encoding of the output collector
// -----------------------------------------------------------------------------
package ntt_pkg;

  localparam int MAX_DEPTH = 10;
  localparam int PE_DEPTH  = 4;
  localparam int Q_DEFAULT = 12289;

  localparam logic [1:0] OP_NTT  = 2'd0;
  localparam logic [1:0] OP_INTT = 2'd1;
  localparam logic [1:0] OP_PWM  = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READY   = 2'd3
  } collector_state_e;

endpackage

// File: rtl/ntt_out_ram.sv
// -----------------------------------------------------------------------------
// ntt_out_ram
// Simple dual-port RAM, 2^ADDR_W x DATA_W: one write port, one registered
// read port. The read data register clears on reset and holds its value
// when no read is requested; the storage array is never cleared.
//   i_clk, i_reset      : clock, synchronous active-high reset (read reg only)
//   i_wr_en/addr/data   : write port, written on the rising edge
//   i_rd_en/addr        : read request
//   o_rd_data           : read data, valid the cycle after i_rd_en
// -----------------------------------------------------------------------------
module ntt_out_ram #(
  parameter int ADDR_W = ntt_pkg::MAX_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // read data register is cleared.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)      r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ntt_dout_collector.sv
// -----------------------------------------------------------------------------
// ntt_dout_collector
// Captures the serial dout0 stream of NTT1024 after done, applies the final
// conditional subtraction of q, undoes the two-half interleave (even word m
// -> m>>1, odd word m -> (m>>1)+N/2) and stores the polynomial in a local RAM
// that the host reads in natural order once ready is high.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_done                : pulse that arms (or restarts) a capture
//   i_ring_depth, i_q     : log2 N and modulus, sampled with i_done
//   i_dout_valid, i_dout0 : result stream
//   i_rd_en, i_rd_addr    : host read request (honoured only when ready)
//   o_rd_data, o_rd_valid : read data, one cycle after the request
//   o_busy, o_ready       : capture in progress / polynomial complete
//   o_overrun             : sticky protocol-error flag
//   o_word_cnt            : words accepted in the current capture
// -----------------------------------------------------------------------------
module ntt_dout_collector #(
  parameter int MAX_DEPTH = ntt_pkg::MAX_DEPTH,
  parameter int DATA_W    = 32,
  parameter int Q_DEFAULT = ntt_pkg::Q_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_done,
  input  logic [3:0]           i_ring_depth,
  input  logic [DATA_W-1:0]    i_q,
  input  logic                 i_dout_valid,
  input  logic [DATA_W-1:0]    i_dout0,
  input  logic                 i_rd_en,
  input  logic [MAX_DEPTH-1:0] i_rd_addr,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_busy,
  output logic                 o_ready,
  output logic                 o_overrun,
  output logic [MAX_DEPTH:0]   o_word_cnt
);

  import ntt_pkg::*;

  localparam int         AW         = MAX_DEPTH;
  localparam int         CW         = MAX_DEPTH + 1;
  localparam logic [3:0] DEPTH_FULL = 4'(MAX_DEPTH);

  collector_state_e  r_state;
  logic [3:0]        r_n_log;     // latched log2 N
  logic [DATA_W-1:0] r_q;
  logic [CW-1:0]     r_word_cnt;
  logic              r_overrun;
  logic              r_rd_valid;
  logic              r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic [3:0]        w_depth_eff;
  logic [AW-1:0]     w_m;
  logic [AW-1:0]     w_half;
  logic [AW-1:0]     w_addr;
  logic [CW-1:0]     w_last_idx;
  logic [DATA_W-1:0] w_reduced;
  logic              w_accept;
  logic              w_rd_fire;
  logic              w_in_capture;

  // Out-of-range ring depths fall back to the largest ring.
  assign w_depth_eff = (i_ring_depth == 4'd0 || i_ring_depth > DEPTH_FULL)
                       ? DEPTH_FULL : i_ring_depth;

  // Interleave is undone from the latched N, so bits above log2 N stay zero.
  assign w_m        = r_word_cnt[AW-1:0];
  assign w_half     = AW'(1) << (r_n_log - 4'd1);
  assign w_addr     = (w_m >> 1) + (w_m[0] ? w_half : '0);
  assign w_last_idx = (CW'(1) << r_n_log) - CW'(1);

  // Single conditional subtraction; inputs >= 2q stay >= q by design.
  assign w_reduced  = (i_dout0 >= r_q) ? i_dout0 - r_q : i_dout0;

  // A simultaneous done wins over dout_valid and drops the word.
  assign w_accept     = (r_state == ST_CAPTURE) && i_dout_valid && !i_done;
  assign w_rd_fire    = (r_state == ST_READY) && i_rd_en;
  assign w_in_capture = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_n_log    <= DEPTH_FULL;
      r_q        <= DATA_W'(Q_DEFAULT);
      r_word_cnt <= '0;
      r_overrun  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_wr_en    <= w_accept;
      if (i_done) begin
        // done mid-capture restarts and flags; otherwise it clears the flag.
        r_state    <= ST_CAPTURE;
        r_n_log    <= w_depth_eff;
        r_q        <= i_q;
        r_word_cnt <= '0;
        r_overrun  <= w_in_capture;
      end else begin
        case (r_state)
          ST_CAPTURE: begin
            if (i_dout_valid) begin
              r_word_cnt <= r_word_cnt + CW'(1);
              if (r_word_cnt == w_last_idx) r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            r_state <= ST_READY;
            if (i_dout_valid) r_overrun <= 1'b1;
          end
          default: begin
            if (i_dout_valid) r_overrun <= 1'b1;
          end
        endcase
      end
    end
  end

  // Write stage 1: reduced word and address, no reset needed (qualified by r_wr_en).
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_wr_addr <= w_addr;
      r_wr_data <= w_reduced;
    end
  end

  ntt_out_ram #(
    .ADDR_W (AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (r_wr_en),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (r_wr_data),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_rd_valid = r_rd_valid;
  assign o_busy     = w_in_capture;
  assign o_ready    = (r_state == ST_READY);
  assign o_overrun  = r_overrun;
  assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_ntt_dout_collector.sv
// -----------------------------------------------------------------------------
// tb_ntt_dout_collector
// Directed bench for ntt_dout_collector: a behavioural model tracks the
// expected mode, counters and reordered polynomial; a compare process checks
// every DUT output on each falling edge, and literal expectations pin the
// model at the interesting points.
// -----------------------------------------------------------------------------
module tb_ntt_dout_collector;

  localparam int N_MAX = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done = 1'b0;
  logic [3:0]  ring_depth = 4'd10;
  logic [31:0] q = 32'd12289;
  logic        dv = 1'b0;
  logic [31:0] dout0 = '0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_busy, o_ready, o_overrun;
  logic [10:0] o_word_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ntt_dout_collector dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_done       (done),
    .i_ring_depth (ring_depth),
    .i_q          (q),
    .i_dout_valid (dv),
    .i_dout0      (dout0),
    .i_rd_en      (rd_en),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .o_busy       (o_busy),
    .o_ready      (o_ready),
    .o_overrun    (o_overrun),
    .o_word_cnt   (o_word_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 collecting, 2 finishing last write, 3 polynomial held
  int          m_mode, m_cnt, m_n;
  logic [31:0] m_q;
  bit          m_ovr, m_rdv;
  logic [31:0] m_rdd;
  logic [31:0] m_mem [N_MAX];

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_n = N_MAX; m_q = 32'd12289;
      m_ovr = 0; m_rdv = 0; m_rdd = '0;
    end else begin
      m_rdv = (m_mode == 3) && rd_en;
      if (m_rdv) m_rdd = m_mem[rd_addr];
      if (done) begin
        m_ovr  = (m_mode == 1 || m_mode == 2);
        m_n    = (ring_depth == 0 || ring_depth > 10) ? N_MAX : (1 << ring_depth);
        m_q    = q;
        m_cnt  = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (dv) begin
          m_mem[m_cnt / 2 + (m_cnt % 2) * (m_n / 2)] = (dout0 >= m_q) ? dout0 - m_q : dout0;
          m_cnt++;
          if (m_cnt == m_n) m_mode = 2;
        end
      end else begin
        if (dv) m_ovr = 1;
        if (m_mode == 2) m_mode = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     o_busy,     (m_mode == 1 || m_mode == 2));
      check("ready",    o_ready,    (m_mode == 3));
      check("overrun",  o_overrun,  m_ovr);
      check("word_cnt", o_word_cnt, m_cnt);
      check("rd_valid", o_rd_valid, m_rdv);
      check("rd_data",  o_rd_data,  m_rdd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; done = 1'b0; dv = 1'b0; rd_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic pulse_done(input logic [3:0] rdep, input logic [31:0] qq);
    done = 1'b1; ring_depth = rdep; q = qq;
    tick();
    done = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int kind, input int m);
    case (kind)
      1: return 32'(m + 17);
      2: return 32'(3 * m);
      3: return 32'(m ^ 1445);
      4: return 32'(m + 5000);
      5: case (m)
           0: return 32'd12289;
           1: return 32'd12290;
           2: return 32'd24577;
           3: return 32'd12288;
           default: return 32'(m);
         endcase
      default: return 32'(m);
    endcase
  endfunction

  task automatic send_seq(input int n, input int kind);
    for (int m = 0; m < n; m++) begin
      dv = 1'b1; dout0 = word_of(kind, m);
      tick();
    end
    dv = 1'b0;
  endtask

  task automatic read_expect(input int addr, input logic [31:0] exp, input string nm);
    rd_en = 1'b1; rd_addr = 10'(addr);
    tick();
    rd_en = 1'b0;
    check({nm, "_valid"}, o_rd_valid, 1'b1);
    check(nm, o_rd_data, exp);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();
    check("rst_busy",    o_busy, 1'b0);
    check("rst_ready",   o_ready, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_cnt",     o_word_cnt, 11'd0);
    check("rst_rd_data", o_rd_data, 32'd0);

    // 1: full ring, identity data
    pulse_done(4'd10, 32'd12289);
    send_seq(1024, 0);
    check("t1_ready_t1", o_ready, 1'b0);
    tick();
    check("t1_ready_t2", o_ready, 1'b1);
    check("t1_cnt",      o_word_cnt, 11'd1024);
    check("t1_overrun",  o_overrun, 1'b0);
    read_expect(0,    32'd0,    "t1_a0");
    read_expect(1,    32'd2,    "t1_a1");
    read_expect(512,  32'd1,    "t1_a512");
    read_expect(1023, 32'd1023, "t1_a1023");

    // 2: reduction boundaries
    pulse_done(4'd10, 32'd12289);
    send_seq(1024, 5);
    tick();
    read_expect(0,   32'd0,     "t2_a0");
    read_expect(512, 32'd1,     "t2_a512");
    read_expect(1,   32'd12288, "t2_a1");
    read_expect(513, 32'd12288, "t2_a513");

    // 3: small ring
    pulse_done(4'd4, 32'd17);
    send_seq(16, 1);
    tick();
    check("t3_ready", o_ready, 1'b1);
    check("t3_cnt",   o_word_cnt, 11'd16);
    read_expect(3,  32'd6,  "t3_a3");
    read_expect(11, 32'd7,  "t3_a11");
    read_expect(15, 32'd15, "t3_a15");

    // 4: stray word in IDLE, preloaded location above N survives
    do_reset();
    dv = 1'b1; dout0 = 32'hDEAD;
    tick();
    dv = 1'b0;
    check("t4_overrun_idle", o_overrun, 1'b1);
    pulse_done(4'd4, 32'd17);
    check("t4_overrun_clr", o_overrun, 1'b0);
    send_seq(16, 1);
    tick();
    read_expect(100, 32'd200, "t4_a100");
    dv = 1'b1; dout0 = 32'd5;
    tick();
    dv = 1'b0;
    check("t4_overrun_ready", o_overrun, 1'b1);

    // 5: restart at word 300
    pulse_done(4'd10, 32'd12289);
    send_seq(300, 4);
    dv = 1'b1; dout0 = 32'd777;
    pulse_done(4'd10, 32'd12289);
    dv = 1'b0;
    check("t5_cnt",     o_word_cnt, 11'd0);
    check("t5_overrun", o_overrun, 1'b1);
    send_seq(1024, 2);
    tick();
    check("t5_ready",    o_ready, 1'b1);
    check("t5_overrun2", o_overrun, 1'b1);
    read_expect(1,   32'd6,   "t5_a1");
    read_expect(600, 32'd531, "t5_a600");

    // 6: reset mid-capture
    pulse_done(4'd10, 32'd12289);
    send_seq(500, 4);
    do_reset();
    check("t6_busy",  o_busy, 1'b0);
    check("t6_ready", o_ready, 1'b0);
    rd_en = 1'b1; rd_addr = 10'd5;
    tick();
    rd_en = 1'b0;
    check("t6_rd_valid", o_rd_valid, 1'b0);
    pulse_done(4'd10, 32'd12289);
    send_seq(1024, 3);
    tick();
    check("t6_ready2", o_ready, 1'b1);
    read_expect(0,   32'd1445,           "t6_a0");
    read_expect(513, 32'(3 ^ 1445),      "t6_a513");
    read_expect(700, 32'(377 ^ 1445),    "t6_a700");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
